// File: rtl/ldpc_pkg.sv
// ----------------------------------------------------------------------------
// ldpc_pkg
// Shared definitions for the LDPC check-node and variable-node stages.
//   MSG_WIDTH_DEFAULT : default message width (sign + magnitude bits)
//   MAG_WIDTH_DEFAULT : magnitude width for the default message width
//   POS_MAX           : largest magnitude for the default message width
//   SIGN_POS/MAG_MSB/MAG_LSB : sign-magnitude field positions (default width)
//   TC_W              : working width of the sign-magnitude to two's
//                       complement helper; callers keep the low bits they need
//   sm_to_tc()        : sign-magnitude to two's complement conversion
// ----------------------------------------------------------------------------
package ldpc_pkg;

  localparam int MSG_WIDTH_DEFAULT = 6;
  localparam int MAG_WIDTH_DEFAULT = MSG_WIDTH_DEFAULT - 1;
  localparam logic [MAG_WIDTH_DEFAULT-1:0] POS_MAX = '1;

  localparam int SIGN_POS = MSG_WIDTH_DEFAULT - 1;
  localparam int MAG_MSB  = MSG_WIDTH_DEFAULT - 2;
  localparam int MAG_LSB  = 0;

  localparam int TC_W = 16;

  // Negating a zero magnitude yields zero, so negative zero never
  // produces a non-zero two's complement value.
  function automatic logic [TC_W-1:0] sm_to_tc(input logic sign,
                                               input logic [TC_W-1:0] mag);
    logic [TC_W-1:0] res;
    res = sign ? (~mag + 1'b1) : mag;
    return res;
  endfunction

endpackage

// File: rtl/cn_min_track.sv
// ----------------------------------------------------------------------------
// cn_min_track
// Combinational min1/min2/index update for one incoming magnitude.
//   mag       : magnitude of the incoming message
//   pos       : position of the message within the row
//   min1/min2 : current smallest and second-smallest magnitudes
//   idx       : position of the current min1
//   min1_next/min2_next/idx_next : updated tracker values
// ----------------------------------------------------------------------------
module cn_min_track
  import ldpc_pkg::*;
#(
  parameter int MAG_W = MAG_WIDTH_DEFAULT,
  parameter int IDX_W = 3
) (
  input  logic [MAG_W-1:0] mag,
  input  logic [IDX_W-1:0] pos,
  input  logic [MAG_W-1:0] min1,
  input  logic [MAG_W-1:0] min2,
  input  logic [IDX_W-1:0] idx,
  output logic [MAG_W-1:0] min1_next,
  output logic [MAG_W-1:0] min2_next,
  output logic [IDX_W-1:0] idx_next
);

  // Strict comparisons: a magnitude equal to min1 becomes min2 and the
  // index of the earlier occurrence is kept.
  always_comb begin
    min1_next = min1;
    min2_next = min2;
    idx_next  = idx;
    if (mag < min1) begin
      min2_next = min1;
      min1_next = mag;
      idx_next  = pos;
    end else if (mag < min2) begin
      min2_next = mag;
    end
  end

endmodule

// File: rtl/cn_serial_minsum.sv
// ----------------------------------------------------------------------------
// cn_serial_minsum
// Serial min-sum check-node unit. Takes DEG sign-magnitude v2c messages per
// row, one per transfer, and emits DEG two's complement c2v messages from a
// one-row snapshot so the next row can accumulate while this one drains.
// Optional feature macro: CN_OFFSET_EN (offset min-sum, subtracts OFFSET
// from output magnitudes with clamping at zero).
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_v2c_valid  : v2c message valid
//   i_v2c        : v2c message, sign-magnitude, msb = sign
//   o_v2c_ready  : unit can accept i_v2c
//   o_c2v_valid  : c2v beat valid
//   i_c2v_ready  : consumer accepts the c2v beat
//   o_c2v        : c2v message, two's complement
//   o_c2v_last   : marks beat DEG-1 of a row
//   o_parity_ok  : row sign XOR is zero (qualified by o_c2v_valid)
// ----------------------------------------------------------------------------
module cn_serial_minsum
  import ldpc_pkg::*;
#(
  parameter int MSG_WIDTH = MSG_WIDTH_DEFAULT,
  parameter int DEG       = 6,
  parameter int OFFSET    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_v2c_valid,
  input  logic [MSG_WIDTH-1:0] i_v2c,
  output logic                 o_v2c_ready,
  output logic                 o_c2v_valid,
  input  logic                 i_c2v_ready,
  output logic [MSG_WIDTH-1:0] o_c2v,
  output logic                 o_c2v_last,
  output logic                 o_parity_ok
);

  localparam int MAG_W = MSG_WIDTH - 1;
  localparam int IDX_W = (DEG > 1) ? $clog2(DEG) : 1;
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(DEG - 1);
  localparam logic [MAG_W-1:0] MAG_MAX  = '1;
  localparam logic [MAG_W-1:0] OFF_M    = MAG_W'(OFFSET);

  // accumulator for the row currently arriving
  logic [IDX_W-1:0] in_cnt;
  logic [MAG_W-1:0] min1, min2;
  logic [IDX_W-1:0] idx;
  logic             sxor;
  logic [DEG-1:0]   sgn;

  // snapshot of the completed row being drained
  logic             snap_valid;
  logic [IDX_W-1:0] out_cnt;
  logic [MAG_W-1:0] snap_min1, snap_min2;
  logic [IDX_W-1:0] snap_idx;
  logic             snap_sxor;
  logic [DEG-1:0]   snap_sgn;

  logic [MAG_W-1:0] in_mag;
  logic             in_sign;
  logic [MAG_W-1:0] base_min1, base_min2;
  logic [IDX_W-1:0] base_idx;
  logic             base_sxor;
  logic [MAG_W-1:0] min1_next, min2_next;
  logic [IDX_W-1:0] idx_next;
  logic             sxor_next;
  logic [DEG-1:0]   sgn_next;

  logic in_xfer, out_xfer, out_last_xfer;

  assign in_mag  = i_v2c[MSG_WIDTH-2:0];
  assign in_sign = i_v2c[MSG_WIDTH-1];

  // The first element of a row starts from a fresh accumulator instead of
  // the stale values left behind by the previous row.
  assign base_min1 = (in_cnt == '0) ? MAG_MAX : min1;
  assign base_min2 = (in_cnt == '0) ? MAG_MAX : min2;
  assign base_idx  = (in_cnt == '0) ? '0 : idx;
  assign base_sxor = (in_cnt == '0) ? 1'b0 : sxor;

  cn_min_track #(
    .MAG_W(MAG_W),
    .IDX_W(IDX_W)
  ) u_min_track (
    .mag      (in_mag),
    .pos      (in_cnt),
    .min1     (base_min1),
    .min2     (base_min2),
    .idx      (base_idx),
    .min1_next(min1_next),
    .min2_next(min2_next),
    .idx_next (idx_next)
  );

  assign sxor_next = base_sxor ^ in_sign;

  always_comb begin
    sgn_next         = sgn;
    sgn_next[in_cnt] = in_sign;
  end

  assign out_xfer      = snap_valid & i_c2v_ready;
  assign out_last_xfer = out_xfer & (out_cnt == LAST_POS);

  // Only the final element of a row has to wait, and only while the
  // snapshot is still occupied and not being emptied this cycle.
  assign o_v2c_ready = !((in_cnt == LAST_POS) && snap_valid && !out_last_xfer);
  assign in_xfer     = i_v2c_valid & o_v2c_ready;

  // Drain is handled before load so that a row end coinciding with the
  // last output beat leaves the new snapshot valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_cnt     <= '0;
      min1       <= '0;
      min2       <= '0;
      idx        <= '0;
      sxor       <= 1'b0;
      sgn        <= '0;
      snap_valid <= 1'b0;
      out_cnt    <= '0;
      snap_min1  <= '0;
      snap_min2  <= '0;
      snap_idx   <= '0;
      snap_sxor  <= 1'b0;
      snap_sgn   <= '0;
    end else begin
      if (out_xfer) begin
        if (out_cnt == LAST_POS) begin
          out_cnt    <= '0;
          snap_valid <= 1'b0;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end
      if (in_xfer) begin
        if (in_cnt == LAST_POS) begin
          in_cnt     <= '0;
          snap_min1  <= min1_next;
          snap_min2  <= min2_next;
          snap_idx   <= idx_next;
          snap_sxor  <= sxor_next;
          snap_sgn   <= sgn_next;
          snap_valid <= 1'b1;
          out_cnt    <= '0;
        end else begin
          in_cnt <= in_cnt + 1'b1;
          min1   <= min1_next;
          min2   <= min2_next;
          idx    <= idx_next;
          sxor   <= sxor_next;
          sgn    <= sgn_next;
        end
      end
    end
  end

  // Output path reads only snapshot registers, so the beat holds steady
  // while the consumer stalls.
  logic [MAG_W-1:0] mag_sel, mag_out;
  logic             out_sign;
  logic [TC_W-1:0]  tc_wide;

  assign mag_sel  = (out_cnt == snap_idx) ? snap_min2 : snap_min1;
  assign out_sign = snap_sxor ^ snap_sgn[out_cnt];

`ifdef CN_OFFSET_EN
  assign mag_out = (mag_sel > OFF_M) ? (mag_sel - OFF_M) : '0;
`else
  logic [MAG_W-1:0] unused_offset;
  assign unused_offset = OFF_M;
  assign mag_out       = mag_sel;
`endif

  assign tc_wide = sm_to_tc(out_sign, {{(TC_W-MAG_W){1'b0}}, mag_out});

  logic unused_tc_hi;
  assign unused_tc_hi = ^tc_wide[TC_W-1:MSG_WIDTH];

  assign o_c2v_valid = snap_valid;
  assign o_c2v       = tc_wide[MSG_WIDTH-1:0];
  assign o_c2v_last  = snap_valid & (out_cnt == LAST_POS);
  assign o_parity_ok = snap_valid & ~snap_sxor;

endmodule

// File: tb/tb_cn_serial_minsum.sv
// ----------------------------------------------------------------------------
// tb_cn_serial_minsum
// Directed bench for cn_serial_minsum (MSG_WIDTH=6, DEG=6, OFFSET=1).
// Expected beats are queued as rows are issued; a separate monitor pops and
// compares whenever the DUT presents a c2v beat. Honours CN_OFFSET_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cn_serial_minsum;

  typedef logic [5:0] row_t [6];
  typedef struct {
    logic [5:0] c2v;
    logic       last;
    logic       par;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_v2c_valid = 1'b0;
  logic [5:0] i_v2c = '0;
  logic       o_v2c_ready;
  logic       o_c2v_valid;
  logic       i_c2v_ready = 1'b1;
  logic [5:0] o_c2v;
  logic       o_c2v_last;
  logic       o_parity_ok;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  row_t in1, in2, in3, in4, ex1, ex2, ex3, ex4;

  cn_serial_minsum #(
    .MSG_WIDTH(6),
    .DEG(6),
    .OFFSET(1)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_v2c_valid(i_v2c_valid),
    .i_v2c      (i_v2c),
    .o_v2c_ready(o_v2c_ready),
    .o_c2v_valid(o_c2v_valid),
    .i_c2v_ready(i_c2v_ready),
    .o_c2v      (o_c2v),
    .o_c2v_last (o_c2v_last),
    .o_parity_ok(o_parity_ok)
  );

  always #5 i_clk = ~i_clk;

  // Compare one value and record the outcome
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Present one v2c message and wait (bounded) until it is accepted
  task automatic sendOne(input logic [5:0] v, output int waits);
    @(negedge i_clk);
    i_v2c_valid = 1'b1;
    i_v2c       = v;
    #1;
    waits = 0;
    while (!o_v2c_ready && waits < 50) begin
      @(negedge i_clk);
      #1;
      waits++;
    end
    if (waits >= 50) checkOutput("v2c_accept_timeout", 32'd1, 32'd0);
    @(posedge i_clk);
    #1;
    i_v2c_valid = 1'b0;
  endtask

  // Queue the expected beats of a row, then issue its six messages
  task automatic applyStimulus(input row_t vin, input row_t vexp, input logic par);
    int w;
    for (int i = 0; i < 6; i++) exp_q.push_back('{c2v: vexp[i], last: (i == 5), par: par});
    for (int i = 0; i < 6; i++) sendOne(vin[i], w);
  endtask

  // Wait (bounded) until every queued beat has been observed
  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_c2v_valid) && n < 200) begin
      @(negedge i_clk);
      #3;
      n++;
    end
    if (n >= 200) checkOutput("drain_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: pop and compare on every output transfer, check hold on stalls
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      #2;
      if (o_c2v_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", {31'd0, o_c2v_valid}, 32'd0);
        end else if (i_c2v_ready) begin
          e = exp_q.pop_front();
          checkOutput("c2v", {26'd0, o_c2v}, {26'd0, e.c2v});
          checkOutput("c2v_last", {31'd0, o_c2v_last}, {31'd0, e.last});
          checkOutput("parity_ok", {31'd0, o_parity_ok}, {31'd0, e.par});
        end else begin
          e = exp_q[0];
          checkOutput("hold_c2v", {26'd0, o_c2v}, {26'd0, e.c2v});
          checkOutput("hold_last", {31'd0, o_c2v_last}, {31'd0, e.last});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    in1 = '{6'h05, 6'h03, 6'h07, 6'h03, 6'h09, 6'h0C};
    in2 = '{6'h0A, 6'h24, 6'h06, 6'h02, 6'h28, 6'h0F};
    in3 = '{6'h21, 6'h29, 6'h34, 6'h1F, 6'h06, 6'h0E};
    in4 = '{6'h20, 6'h07, 6'h03, 6'h09, 6'h05, 6'h04};
`ifdef CN_OFFSET_EN
    ex1 = '{6'h02, 6'h02, 6'h02, 6'h02, 6'h02, 6'h02};
    ex2 = '{6'h01, 6'h3F, 6'h01, 6'h03, 6'h3F, 6'h01};
    ex3 = '{6'h05, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    ex4 = '{6'h02, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
`else
    ex1 = '{6'h03, 6'h03, 6'h03, 6'h03, 6'h03, 6'h03};
    ex2 = '{6'h02, 6'h3E, 6'h02, 6'h04, 6'h3E, 6'h02};
    ex3 = '{6'h06, 6'h01, 6'h01, 6'h3F, 6'h3F, 6'h3F};
    ex4 = '{6'h03, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
`endif

    // reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #2;
    checkOutput("reset_c2v_valid", {31'd0, o_c2v_valid}, 32'd0);
    checkOutput("reset_v2c_ready", {31'd0, o_v2c_ready}, 32'd1);
    checkOutput("reset_c2v", {26'd0, o_c2v}, 32'd0);
    checkOutput("reset_last", {31'd0, o_c2v_last}, 32'd0);
    checkOutput("reset_parity", {31'd0, o_parity_ok}, 32'd0);

    // tie on min1, first beat one cycle after the last input
    applyStimulus(in1, ex1, 1'b1);
    @(negedge i_clk);
    #2;
    checkOutput("latency_valid", {31'd0, o_c2v_valid}, 32'd1);
    waitDrain();

    // mixed signs, even parity
    applyStimulus(in2, ex2, 1'b1);
    waitDrain();

    // odd parity
    applyStimulus(in3, ex3, 1'b0);
    waitDrain();

    // negative zero as min1
    applyStimulus(in4, ex4, 1'b0);
    waitDrain();

    // two rows with the consumer stalled: last input of row 2 must wait
    @(negedge i_clk);
    i_c2v_ready = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back('{c2v: ex1[i], last: (i == 5), par: 1'b1});
    for (int i = 0; i < 6; i++) sendOne(in1[i], w);
    for (int i = 0; i < 6; i++) exp_q.push_back('{c2v: ex2[i], last: (i == 5), par: 1'b1});
    for (int i = 0; i < 5; i++) sendOne(in2[i], w);
    @(negedge i_clk);
    i_v2c_valid = 1'b1;
    i_v2c       = in2[5];
    #1;
    checkOutput("stall_ready", {31'd0, o_v2c_ready}, 32'd0);
    i_c2v_ready = 1'b1;
    w = 0;
    while (!o_v2c_ready && w < 50) begin
      @(negedge i_clk);
      #1;
      w++;
    end
    checkOutput("stall_release_cycles", w, 32'd5);
    @(posedge i_clk);
    #1;
    i_v2c_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      #2;
      checkOutput("no_gap_valid", {31'd0, o_c2v_valid}, 32'd1);
    end
    waitDrain();

    // reset mid-row discards the partial accumulation
    for (int i = 0; i < 3; i++) sendOne(in1[i], w);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #2;
    checkOutput("midreset_valid", {31'd0, o_c2v_valid}, 32'd0);
    checkOutput("midreset_ready", {31'd0, o_v2c_ready}, 32'd1);
    repeat (3) begin
      @(negedge i_clk);
      #2;
      checkOutput("midreset_idle", {31'd0, o_c2v_valid}, 32'd0);
    end
    applyStimulus(in2, ex2, 1'b1);
    waitDrain();

    checkOutput("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
